// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the instruction sequencer and the datapath/memory side.
// master = sequencer (drives control), slave = datapath (drives IR fields and flags).
interface cpu_control_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       N, V, Z;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       write;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0] pc_sel;
  logic [1:0] mem_cmd;
  logic       halt, fault;

  modport master (
    input  opcode, op, cond, N, V, Z,
    output nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, pc_sel, mem_cmd, halt, fault
  );
  modport slave (
    output opcode, op, cond, N, V, Z,
    input  nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, pc_sel, mem_cmd, halt, fault
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Instruction-sequencing Moore FSM with configurable memory wait states,
// call/return branches and a sticky FAULT state for undefined encodings.
module cpu_control_fsm #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  cpu_control_fsm_if.master bus
);
  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B,
    S_ALU, S_WRITE_RD, S_CMP, S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MDATA, S_GET_RD,
    S_PASS, S_MEM_WR, S_BRANCH, S_LINK, S_JUMP, S_HALT, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_done, taken;

  assign wait_done = (cnt_q == CNT_W'(MEM_WAIT));

  always_comb begin
    case (bus.cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = bus.Z;
      3'b010:  taken = !bus.Z;
      3'b011:  taken = bus.N != bus.V;
      3'b100:  taken = (bus.N != bus.V) || bus.Z;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET:     state_d = S_IF1;
      S_IF1: begin
        if (wait_done) state_d = S_IF2;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FAULT;
        case (bus.opcode)
          3'b110: if (bus.op == 2'b10) state_d = S_WRITE_IMM;
                  else if (bus.op == 2'b00) state_d = S_GET_B;
          3'b101: state_d = (bus.op == 2'b11) ? S_GET_B : S_GET_A;
          3'b011, 3'b100: if (bus.op == 2'b00) state_d = S_GET_A;
          3'b001: if (bus.op == 2'b00 && bus.cond <= 3'b100)
                    state_d = taken ? S_BRANCH : S_IF1;
          3'b010: if (bus.op == 2'b00) state_d = S_GET_RD;
                  else if (bus.op[1]) state_d = S_LINK;
          3'b111: state_d = S_HALT;
          default: state_d = S_FAULT;
        endcase
      end
      // The IR is stable from IF2 until the next fetch, so later states route on it.
      S_GET_A:     state_d = (bus.opcode == 3'b011 || bus.opcode == 3'b100) ? S_ADDR : S_GET_B;
      S_GET_B:     state_d = (bus.opcode == 3'b101 && bus.op == 2'b01) ? S_CMP : S_ALU;
      S_ALU:       state_d = S_WRITE_RD;
      S_ADDR:      state_d = S_LD_ADDR;
      S_LD_ADDR:   state_d = (bus.opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD: begin
        if (wait_done) state_d = S_WR_MDATA;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_GET_RD:    state_d = S_PASS;
      S_PASS:      state_d = (bus.opcode == 3'b100) ? S_MEM_WR : S_JUMP;
      S_LINK:      state_d = (bus.op == 2'b11) ? S_BRANCH : S_GET_RD;
      S_WRITE_IMM, S_WRITE_RD, S_CMP, S_WR_MDATA, S_MEM_WR, S_BRANCH, S_JUMP:
                   state_d = S_IF1;
      S_HALT:      state_d = S_HALT;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  always_comb begin
    bus.nsel = 3'b000; bus.loada = 1'b0; bus.loadb = 1'b0; bus.loadc = 1'b0;
    bus.loads = 1'b0; bus.asel = 1'b0; bus.bsel = 1'b0; bus.vsel = 2'b00;
    bus.write = 1'b0; bus.load_ir = 1'b0; bus.load_pc = 1'b0; bus.reset_pc = 1'b0;
    bus.load_addr = 1'b0; bus.addr_sel = 1'b0; bus.pc_sel = 2'b00; bus.mem_cmd = 2'b00;
    bus.halt = 1'b0; bus.fault = 1'b0;
    case (state_q)
      S_RESET:     begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1:       begin bus.addr_sel = 1'b1; bus.mem_cmd = 2'b01; end
      S_IF2:       begin bus.addr_sel = 1'b1; bus.mem_cmd = 2'b01; bus.load_ir = 1'b1; end
      S_UPDATE_PC: bus.load_pc = 1'b1;
      S_WRITE_IMM: begin bus.nsel = 3'b001; bus.vsel = 2'b10; bus.write = 1'b1; end
      S_GET_A:     begin bus.nsel = 3'b001; bus.loada = 1'b1; end
      S_GET_B:     begin bus.nsel = 3'b100; bus.loadb = 1'b1; end
      // MOV reg / MVN take A=0; ADD / AND use the loaded Rn.
      S_ALU:       begin bus.loadc = 1'b1; bus.asel = !(bus.opcode == 3'b101 && !bus.op[0]); end
      S_WRITE_RD:  begin bus.nsel = 3'b010; bus.write = 1'b1; end
      S_CMP:       bus.loads = 1'b1;
      S_ADDR:      begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_LD_ADDR:   bus.load_addr = 1'b1;
      S_MEM_RD:    bus.mem_cmd = 2'b01;
      S_WR_MDATA:  begin bus.mem_cmd = 2'b01; bus.nsel = 3'b010; bus.vsel = 2'b11; bus.write = 1'b1; end
      S_GET_RD:    begin bus.nsel = 3'b010; bus.loadb = 1'b1; end
      S_PASS:      begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_MEM_WR:    bus.mem_cmd = 2'b10;
      S_BRANCH:    begin bus.load_pc = 1'b1; bus.pc_sel = 2'b01; end
      S_LINK:      begin bus.nsel = 3'b001; bus.vsel = 2'b01; bus.write = 1'b1; end
      S_JUMP:      begin bus.load_pc = 1'b1; bus.pc_sel = 2'b10; end
      S_HALT:      bus.halt = 1'b1;
      S_FAULT:     bus.fault = 1'b1;
      default:     ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed-vector bench: two instances (MEM_WAIT=0 and MEM_WAIT=3) checked cycle by cycle.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic rst0, rst3;
  int   nvec = 0, nmis = 0;
  logic [22:0] expq[$];

  always #5 clk = ~clk;

  cpu_control_fsm_if if0 ();
  cpu_control_fsm_if if3 ();
  cpu_control_fsm #(.MEM_WAIT(0), .CNT_W(4)) u0 (.clk(clk), .reset(rst0), .bus(if0.master));
  cpu_control_fsm #(.MEM_WAIT(3), .CNT_W(4)) u3 (.clk(clk), .reset(rst3), .bus(if3.master));

  // {nsel, loada/b/c/s, asel/bsel, vsel, write, load_ir/load_pc/reset_pc/load_addr/addr_sel, pc_sel, mem_cmd, halt/fault}
  function automatic logic [22:0] mk(input logic [2:0] nsel, input logic [3:0] ld, input logic [1:0] sel,
                                     input logic [1:0] vsel, input logic wr, input logic [4:0] f5,
                                     input logic [1:0] pcs, input logic [1:0] mc, input logic [1:0] hf);
    return {nsel, ld, sel, vsel, wr, f5, pcs, mc, hf};
  endfunction

  logic [22:0] E_RST, E_IF1, E_IF2, E_UPD, E_DEC, E_WIMM, E_GETA, E_GETB, E_ALUA, E_ALU, E_WRD,
               E_CMP, E_ADDR, E_LDA, E_MRD, E_WRM, E_GETRD, E_PASS, E_MWR, E_BR, E_LINK, E_JMP,
               E_HALT, E_FLT;

  initial begin
    E_RST  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b01100, 0, 0, 0);
    E_IF1  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00001, 0, 1, 0);
    E_IF2  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b10001, 0, 1, 0);
    E_UPD  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b01000, 0, 0, 0);
    E_DEC  = '0;
    E_WIMM = mk(1, 4'b0000, 2'b00, 2, 1, 5'b00000, 0, 0, 0);
    E_GETA = mk(1, 4'b1000, 2'b00, 0, 0, 5'b00000, 0, 0, 0);
    E_GETB = mk(4, 4'b0100, 2'b00, 0, 0, 5'b00000, 0, 0, 0);
    E_ALUA = mk(0, 4'b0010, 2'b10, 0, 0, 5'b00000, 0, 0, 0);
    E_ALU  = mk(0, 4'b0010, 2'b00, 0, 0, 5'b00000, 0, 0, 0);
    E_WRD  = mk(2, 4'b0000, 2'b00, 0, 1, 5'b00000, 0, 0, 0);
    E_CMP  = mk(0, 4'b0001, 2'b00, 0, 0, 5'b00000, 0, 0, 0);
    E_ADDR = mk(0, 4'b0010, 2'b01, 0, 0, 5'b00000, 0, 0, 0);
    E_LDA  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00010, 0, 0, 0);
    E_MRD  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00000, 0, 1, 0);
    E_WRM  = mk(2, 4'b0000, 2'b00, 3, 1, 5'b00000, 0, 1, 0);
    E_GETRD= mk(2, 4'b0100, 2'b00, 0, 0, 5'b00000, 0, 0, 0);
    E_PASS = mk(0, 4'b0010, 2'b10, 0, 0, 5'b00000, 0, 0, 0);
    E_MWR  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00000, 0, 2, 0);
    E_BR   = mk(0, 4'b0000, 2'b00, 0, 0, 5'b01000, 1, 0, 0);
    E_LINK = mk(1, 4'b0000, 2'b00, 1, 1, 5'b00000, 0, 0, 0);
    E_JMP  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b01000, 2, 0, 0);
    E_HALT = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00000, 0, 0, 2'b10);
    E_FLT  = mk(0, 4'b0000, 2'b00, 0, 0, 5'b00000, 0, 0, 2'b01);
  end

  function automatic logic [22:0] pk(input bit w3);
    if (w3) return {if3.nsel, if3.loada, if3.loadb, if3.loadc, if3.loads, if3.asel, if3.bsel, if3.vsel,
                    if3.write, if3.load_ir, if3.load_pc, if3.reset_pc, if3.load_addr, if3.addr_sel,
                    if3.pc_sel, if3.mem_cmd, if3.halt, if3.fault};
    return {if0.nsel, if0.loada, if0.loadb, if0.loadc, if0.loads, if0.asel, if0.bsel, if0.vsel,
            if0.write, if0.load_ir, if0.load_pc, if0.reset_pc, if0.load_addr, if0.addr_sel,
            if0.pc_sel, if0.mem_cmd, if0.halt, if0.fault};
  endfunction

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_rst(input bit w3, input logic v);
    if (w3) rst3 = v; else rst0 = v;
  endtask

  task automatic pf(input int w);
    for (int i = 0; i <= w; i++) expq.push_back(E_IF1);
    expq.push_back(E_IF2); expq.push_back(E_UPD); expq.push_back(E_DEC);
  endtask

  // Reset, load the IR fields/flags, then compare each cycle against expq.
  task automatic run(input string tag, input bit w3, input logic [15:0] ir, input logic [2:0] nvz);
    if (w3) begin
      {if3.opcode, if3.op, if3.cond} = ir[15:8]; {if3.N, if3.V, if3.Z} = nvz;
    end else begin
      {if0.opcode, if0.op, if0.cond} = ir[15:8]; {if0.N, if0.V, if0.Z} = nvz;
    end
    set_rst(w3, 1'b1); step(); chk({tag, ":rst"}, pk(w3), E_RST);
    set_rst(w3, 1'b0);
    foreach (expq[i]) begin
      step(); chk($sformatf("%s:c%0d", tag, i + 1), pk(w3), expq[i]);
    end
    expq.delete();
  endtask

  task automatic rst_mid(input string tag, input bit w3);
    set_rst(w3, 1'b1); step(); chk({tag, ":rst"}, pk(w3), E_RST);
    set_rst(w3, 1'b0); step(); chk({tag, ":if1"}, pk(w3), E_IF1);
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    {if0.opcode, if0.op, if0.cond, if0.N, if0.V, if0.Z} = '0;
    {if3.opcode, if3.op, if3.cond, if3.N, if3.V, if3.Z} = '0;
    step(); step();
    chk("reset0", pk(0), E_RST);
    chk("reset3", pk(1), E_RST);

    pf(0); expq.push_back(E_WIMM); expq.push_back(E_IF1);
    run("movimm", 0, 16'hD005, 3'b000);
    pf(0); expq.push_back(E_GETA); expq.push_back(E_GETB); expq.push_back(E_ALU);
    expq.push_back(E_WRD); expq.push_back(E_IF1);
    run("add", 0, 16'hA000, 3'b000);
    pf(0); expq.push_back(E_GETA); expq.push_back(E_GETB); expq.push_back(E_ALU);
    expq.push_back(E_WRD); expq.push_back(E_IF1);
    run("and", 0, 16'hB000, 3'b000);
    pf(0); expq.push_back(E_GETB); expq.push_back(E_ALUA); expq.push_back(E_WRD); expq.push_back(E_IF1);
    run("mvn", 0, 16'hB800, 3'b000);
    pf(0); expq.push_back(E_GETB); expq.push_back(E_ALUA); expq.push_back(E_WRD); expq.push_back(E_IF1);
    run("movreg", 0, 16'hC000, 3'b000);
    pf(0); expq.push_back(E_GETA); expq.push_back(E_GETB); expq.push_back(E_CMP); expq.push_back(E_IF1);
    run("cmp", 0, 16'hA800, 3'b000);
    pf(0); expq.push_back(E_GETA); expq.push_back(E_ADDR); expq.push_back(E_LDA);
    expq.push_back(E_MRD); expq.push_back(E_WRM); expq.push_back(E_IF1);
    run("ldr0", 0, 16'h6000, 3'b000);
    pf(3); expq.push_back(E_GETA); expq.push_back(E_ADDR); expq.push_back(E_LDA);
    for (int i = 0; i < 4; i++) expq.push_back(E_MRD);
    expq.push_back(E_WRM); expq.push_back(E_IF1);
    run("ldr3", 1, 16'h6000, 3'b000);
    pf(0); expq.push_back(E_GETA); expq.push_back(E_ADDR); expq.push_back(E_LDA);
    expq.push_back(E_GETRD); expq.push_back(E_PASS); expq.push_back(E_MWR); expq.push_back(E_IF1);
    run("str", 0, 16'h8000, 3'b000);

    pf(0); expq.push_back(E_BR); expq.push_back(E_IF1);
    run("beq_t", 0, 16'h2100, 3'b001);
    pf(0); expq.push_back(E_IF1); expq.push_back(E_IF2);
    run("beq_n", 0, 16'h2100, 3'b000);
    pf(0); expq.push_back(E_BR); expq.push_back(E_IF1);
    run("blt_t", 0, 16'h2300, 3'b100);
    pf(0); expq.push_back(E_IF1);
    run("ble_n", 0, 16'h2400, 3'b110);
    pf(0); expq.push_back(E_BR); expq.push_back(E_IF1);
    run("ble_z", 0, 16'h2400, 3'b111);
    pf(0); expq.push_back(E_BR); expq.push_back(E_IF1);
    run("bne_t", 0, 16'h2200, 3'b000);
    pf(0); expq.push_back(E_FLT); expq.push_back(E_FLT);
    run("bcond5", 0, 16'h2500, 3'b001);

    pf(0); expq.push_back(E_LINK); expq.push_back(E_BR); expq.push_back(E_IF1);
    run("bl", 0, 16'h5F00, 3'b000);
    pf(0); expq.push_back(E_GETRD); expq.push_back(E_PASS); expq.push_back(E_JMP); expq.push_back(E_IF1);
    run("bx", 0, 16'h4000, 3'b000);
    pf(0); expq.push_back(E_LINK); expq.push_back(E_GETRD); expq.push_back(E_PASS);
    expq.push_back(E_JMP); expq.push_back(E_IF1);
    run("blx", 0, 16'h5700, 3'b000);

    pf(0); for (int i = 0; i < 20; i++) expq.push_back(E_FLT);
    run("undef", 0, 16'h0000, 3'b000);
    rst_mid("fltclr", 0);
    pf(0); expq.push_back(E_FLT);
    run("undef010_01", 0, 16'h4800, 3'b000);
    pf(3); for (int i = 0; i < 8; i++) expq.push_back(E_HALT);
    run("halt", 1, 16'hE000, 3'b000);
    rst_mid("haltclr", 1);

    pf(0); expq.push_back(E_GETA); expq.push_back(E_ADDR); expq.push_back(E_LDA);
    expq.push_back(E_GETRD); expq.push_back(E_PASS); expq.push_back(E_MWR);
    run("str_abort", 0, 16'h8000, 3'b000);
    rst_mid("str_abort", 0);
    expq.push_back(E_IF1); expq.push_back(E_IF1);
    run("if1_abort", 1, 16'hD005, 3'b000);
    rst_mid("if1_abort", 1);
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("if1_wait%0d", i), pk(1), E_IF1);
    end
    step(); chk("if1_to_if2", pk(1), E_IF2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Parametrised successor to the processor's instruction-sequencing control FSM; it drives the datapath, register file, PC and RAM interface. It adds a configurable memory wait-state count and call/return branches (BL, BX, BLX). Undefined encodings trap to a FAULT state instead of falling back to reset. It sits between the instruction register decoder and the datapath/memory control pins.

## Interface
- MEM_WAIT, default 0: extra cycles held in each memory-read state (0–15).
- CNT_W, default 4: width of the wait counter; MEM_WAIT < 2^CNT_W.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  3  IR[15:13].
- op  in  2  IR[12:11].
- cond  in  3  IR[10:8], branch condition.
- N, V, Z  in  1 each  status flags.
- nsel  out  3  register select: 001 Rn, 010 Rd, 100 Rm.
- loada, loadb, loadc, loads  out  1  datapath register loads.
- asel, bsel  out  1  ALU operand selects (asel=1 → A=0; bsel=1 → sximm5).
- vsel  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata.
- write  out  1  register-file write enable.
- load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1  fetch/address control; addr_sel=1 selects PC.
- pc_sel  out  2  next-PC source: 00 PC+1, 01 PC+sximm8, 10 datapath_out.
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE.
- halt, fault  out  1  status, level.

## Operation
- Moore FSM: every output is decoded from the registered state plus the instruction fields. No output depends on N/V/Z except through the transition taken out of DECODE.
- Outputs not listed for a state are 0. mem_cmd is NONE unless stated.
- Fetch sequence:
  - RESET: reset_pc=1, load_pc=1 → IF1.
  - IF1: addr_sel=1, mem_cmd=READ. Hold for MEM_WAIT extra cycles using the wait counter → IF2.
  - IF2: addr_sel=1, mem_cmd=READ, load_ir=1 → UPDATE_PC.
  - UPDATE_PC: load_pc=1, pc_sel=00 → DECODE.
- MOV imm (110/10): WRITE_IMM (nsel=Rn, vsel=10, write=1) → IF1.
- MOV reg (110/00), MVN (101/11):
  - GET_B: nsel=Rm, loadb=1.
  - ALU: asel=1, loadc=1.
  - WRITE_RD: nsel=Rd, write=1, vsel=00.
  - → IF1.
- ADD (101/00), AND (101/10): GET_A (nsel=Rn, loada=1) → GET_B → ALU (loadc=1) → WRITE_RD → IF1.
- CMP (101/01): GET_A → GET_B → CMP (loads=1) → IF1.
- LDR (011/00):
  - GET_A.
  - ADDR: bsel=1, loadc=1.
  - LD_ADDR: load_addr=1.
  - MEM_RD: addr_sel=0, mem_cmd=READ, held MEM_WAIT extra cycles.
  - WR_MDATA: addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=11, write=1.
  - → IF1.
- STR (100/00):
  - GET_A → ADDR → LD_ADDR.
  - GET_RD: nsel=Rd, loadb=1.
  - PASS: asel=1, loadc=1.
  - MEM_WR: addr_sel=0, mem_cmd=WRITE, single cycle.
  - → IF1.
- B (001/00): branch is taken when the condition holds.
  - cond 000: always. 001: Z. 010: !Z. 011: N≠V. 100: N≠V or Z.
  - Taken: → BRANCH (load_pc=1, pc_sel=01) → IF1.
  - Not taken: → IF1 directly.
  - cond 101–111: → FAULT.
- BL (010/11): LINK (nsel=Rn, vsel=01, write=1; Rn field = R7) → BRANCH → IF1.
- BX (010/00): GET_RD → PASS → JUMP (load_pc=1, pc_sel=10) → IF1.
- BLX (010/10): LINK → GET_RD → PASS → JUMP → IF1.
- HALT (111/xx): → HALT. halt=1; remain until reset.
- Any other opcode/op pair: → FAULT. fault=1; remain until reset.

## Timing
- Reset: when reset is sampled high, the next state is RESET regardless of current state. This aborts any in-flight operation, and mem_cmd reads NONE from that edge.
  - Outputs in RESET: reset_pc=1, load_pc=1, all others 0, halt=0, fault=0.
  - The first IF1 is the cycle after reset is sampled low.
- Fetch latency: IF1 entry to DECODE = 3+MEM_WAIT cycles.
- Wait counter: loads 0 on entering IF1 or MEM_RD. The state exits when count == MEM_WAIT. With MEM_WAIT=0 each read state lasts exactly 1 cycle.
- DECODE: always exactly 1 cycle with all outputs 0.
- Flags are sampled only on the DECODE→next edge. A CMP's loads therefore precedes any dependent branch decode by at least the fetch latency.
- Instruction cycles, DECODE to IF1 inclusive of DECODE, MEM_WAIT=0:
  - MOV imm: 2.
  - ADD: 5.
  - CMP: 4.
  - LDR: 6.
  - STR: 7.
  - B taken: 2; not taken: 1.
  - BL: 3.
  - BX: 4.
  - BLX: 5.
- LDR: each extra MEM_WAIT cycle adds one cycle in MEM_RD. Fetch extra cycles add in IF1.
- mem_cmd=WRITE is asserted for exactly one cycle per STR.

## Test plan
- Reset then MOV R0,#5 (0xD005), MEM_WAIT=0: reset_pc/load_pc high 1 cycle; load_ir pulses 2 cycles after IF1; write=1, nsel=001, vsel=10 in the 5th cycle after reset deasserts; back in IF1 next cycle.
- MEM_WAIT=3, LDR: mem_cmd=READ with addr_sel=0 held 4 consecutive cycles, then write=1, vsel=11 for 1 cycle; the fetch IF1 phase lasts 4 cycles.
- B with cond=001: Z=1 → load_pc=1, pc_sel=01 for one cycle; Z=0 → DECODE goes straight to IF1 with no load_pc.
- BLX: write=1, vsel=01, nsel=001, then loadb with nsel=010, loadc with asel=1, then load_pc with pc_sel=10. Total 5 cycles from DECODE.
- Opcode 000 (undefined) → fault=1 held for 20 cycles and mem_cmd stays NONE; reset clears fault and re-fetches. HALT similarly holds halt=1 until reset.
- Reset asserted during STR MEM_WR and during IF1 wait: mem_cmd=NONE from the next edge, state RESET, then normal fetch.
